dram_rmw_ctrl: RTL
==================

// Module: dram_rmw_ctrl
// PURPOSE
// Data-memory responder behind the MEM stage. Accepts one load/store request at a time over a valid/ready handshake.
// Drives a word-wide synchronous SRAM (1-cycle read latency) and performs byte/half stores by read-modify-write.
// Returns lane-aligned load data for downstream sign/zero extension, with a response handshake.
// PARAMETERS
// AW  10  word-address width of the SRAM (2^AW words, 4*2^AW bytes)
// PORTS
// clk        in   1   clock, all state updates on rising edge
// rst        in   1   synchronous, active-high reset
// req_valid  in   1   request present
// req_ready  out  1   controller can accept request (IDLE only)
// req_adr    in   32  byte address
// req_op     in   2   access size: 00 byte, 01 half, 10 word, 11 reserved
// req_we     in   1   1 store, 0 load
// req_wdin   in   32  store data, value in low lane(s)
// rsp_valid  out  1   response present; held until rsp_ready
// rsp_ready  in   1   consumer accepts response
// rsp_rdo    out  32  load data >> (8*adr[1:0]), zero-filled above; 0 for stores and errors
// rsp_err    out  1   misaligned, out-of-range or reserved-op request
// mem_en     out  1   SRAM access enable
// mem_we     out  1   SRAM write enable (full word)
// mem_adr    out  AW  SRAM word index = adr[AW+1:2]
// mem_wdata  out  32  SRAM write word
// mem_rdata  in   32  SRAM read word, valid the cycle after mem_en && !mem_we
// BEHAVIOUR
// - States: IDLE, RD, CAP, MRG, WR, RESP. Reset -> IDLE.
// - Reset values: req_ready=0 while rst=1, then 1 in IDLE. rsp_valid, rsp_err, rsp_rdo, mem_en, mem_we, mem_adr, mem_wdata = 0.
// - Accept: req_valid && req_ready at edge E0 registers adr/op/we/wdin. req_ready=0 outside IDLE.
// - Error check at accept:
//   - op=11, op=01 with adr[0]!=0, op=10 with adr[1:0]!=0, or adr[31:AW+2]!=0 -> RESP with rsp_err=1, rsp_rdo=0.
//   - No SRAM access on error.
// - Load: IDLE->RD (mem_en=1, mem_we=0) -> CAP (capture mem_rdata shifted by 8*adr[1:0]) -> RESP.
//   - rsp_valid first high in cycle 3 after E0.
// - Word store: IDLE->WR (mem_en=1, mem_we=1, mem_wdata=wdin) -> RESP. rsp_valid in cycle 2.
// - Byte/half store: IDLE->RD -> MRG (mem_en=mem_we=1) -> RESP. rsp_valid in cycle 3.
//   - MRG write word = mem_rdata with the selected lane(s) replaced by wdin[7:0] / wdin[15:0] at offset 8*adr[1:0].
//   - Other bytes are unchanged.
// - RESP: rsp_valid=1 and rsp_rdo/rsp_err stable until rsp_ready. Same edge -> IDLE; new request acceptable the next cycle.
// - mem_en/mem_we are 0 in IDLE, CAP and RESP. mem_adr/mem_wdata hold their last value when not enabled.
// - No back-to-back overlap: at most one outstanding request. req_valid while busy is ignored (requester holds it).
// - Reset mid-operation:
//   - Abort immediately; the pending response is discarded.
//   - mem_en/mem_we are forced 0 in any cycle with rst=1, so an interrupted RMW never writes.
// - Store with rsp_err=1 leaves SRAM untouched. A load response never reports stale data from a previous request.
// TESTING
// 1. Reset, then store word 0xDEADBEEF @0x10, load word @0x10 -> one WR write, rsp_rdo=0xDEADBEEF at cycle 3, rsp_err=0.
// 2. Store byte 0x5A @0x11 over 0xDEADBEEF -> RD then MRG write 0xDEAD5AEF; load byte @0x11 -> rsp_rdo=0x00DEAD5A.
// 3. Store half 0x1234 @0x12 -> word becomes 0x12345AEF. Load half @0x12 -> rsp_rdo=0x00001234.
// 4. Load half @0x13, load word @0x02, op=11, adr=0x1000 (AW=10) -> rsp_err=1, rsp_rdo=0, mem_en never asserted.
// 5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdo stable, req_ready=0. Release -> IDLE next cycle.
// 6. Assert rst during MRG of a byte store -> mem_we=0 that cycle, SRAM word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/dram_rmw_ctrl.sv
// Single-outstanding load/store responder for a word-wide SRAM with 1-cycle read latency.
// Byte and half stores are performed as read-modify-write; loads return lane-aligned data.
module dram_rmw_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [31:0]   req_adr_i,
    input  logic [1:0]    req_op_i,
    input  logic          req_we_i,
    input  logic [31:0]   req_wdin_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdo_o,
    output logic          rsp_err_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        MRG,
        WR,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    off_q;
    logic [1:0]    op_q;
    logic          we_q;
    logic [31:0]   wdin_q;
    logic [AW-1:0] memAdr_q;
    logic [31:0]   memWdata_q;
    logic [31:0]   rspRdo_q;
    logic          rspErr_q;

    logic          accept;
    logic          reqErr;
    logic [4:0]    shamt;
    logic [31:0]   laneMask;
    logic [31:0]   mergeWord;

    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        reqErr = 1'b0;
        if (req_op_i == 2'b11)
            reqErr = 1'b1;
        if (req_op_i == 2'b01 && req_adr_i[0] != 1'b0)
            reqErr = 1'b1;
        if (req_op_i == 2'b10 && req_adr_i[1:0] != 2'b00)
            reqErr = 1'b1;
        if ((req_adr_i >> (AW + 2)) != 32'd0)
            reqErr = 1'b1;
    end

    // Merge the stored lane(s) into the word read back during RD.
    assign shamt     = {off_q, 3'b000};
    assign laneMask  = (op_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    assign mergeWord = (mem_rdata_i & ~(laneMask << shamt)) | ((wdin_q & laneMask) << shamt);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr)
                        state_d = RESP;
                    else if (req_we_i && req_op_i == 2'b10)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? MRG : CAP;
            CAP:     state_d = RESP;
            MRG:     state_d = RESP;
            WR:      state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_q      <= 2'b00;
            op_q       <= 2'b00;
            we_q       <= 1'b0;
            wdin_q     <= 32'd0;
            memAdr_q   <= '0;
            memWdata_q <= 32'd0;
            rspRdo_q   <= 32'd0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        off_q    <= req_adr_i[1:0];
                        op_q     <= req_op_i;
                        we_q     <= req_we_i;
                        wdin_q   <= req_wdin_i;
                        rspRdo_q <= 32'd0;
                        rspErr_q <= reqErr;
                        if (!reqErr)
                            memAdr_q <= req_adr_i[AW+1:2];
                        if (!reqErr && req_we_i && req_op_i == 2'b10)
                            memWdata_q <= req_wdin_i;
                    end
                end
                CAP:     rspRdo_q   <= mem_rdata_i >> shamt;
                MRG:     memWdata_q <= mergeWord;
                default: ;
            endcase
        end
    end

    // Reset gates every strobe so an interrupted RMW can never write.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = memWdata_q;
        if (!rst_i) begin
            case (state_q)
                IDLE: req_ready_o = 1'b1;
                RD:   mem_en_o    = 1'b1;
                MRG: begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_wdata_o = mergeWord;
                end
                WR: begin
                    mem_en_o = 1'b1;
                    mem_we_o = 1'b1;
                end
                RESP:    rsp_valid_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_rdo_o = rspRdo_q;
    assign rsp_err_o = rspErr_q;
    assign mem_adr_o = memAdr_q;

endmodule
